// File: rtl/alu_result_buffer.sv
// alu_result_buffer: 2-entry skid buffer for ALU results, optional ALU_RESULT_STATS_EN push counters
module alu_result_buffer #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] AluOut,
    input  logic             AluZero,
    input  logic [OPW-1:0]   AluOp,
    input  logic             InValid,
    output logic             InReady,
    output logic [WIDTH-1:0] Result,
    output logic             ResultZero,
    output logic [OPW-1:0]   ResultOp,
    output logic             OutValid,
    input  logic             OutReady
`ifdef ALU_RESULT_STATS_EN
    ,
    output logic [15:0]      AcceptCount,
    output logic [15:0]      ZeroCount
`endif
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] skid_out;
    logic skid_zero;
    logic [OPW-1:0] skid_op;
    logic push, pop, load_head, load_skid, move_skid;
    assign InReady  = state != TWO;
    assign OutValid = state != EMPTY;
    assign push     = InValid & InReady;
    assign pop      = OutValid & OutReady;
    always_comb begin
        state_nx  = state;
        load_head = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        case (state)
            EMPTY: begin
                state_nx  = push ? ONE : EMPTY;
                load_head = push;
            end
            ONE: begin
                state_nx  = push ? (pop ? ONE : TWO) : (pop ? EMPTY : ONE);
                load_head = push & pop;
                load_skid = push & ~pop;
            end
            TWO: begin
                state_nx  = pop ? ONE : TWO;
                move_skid = pop;
            end
            default: state_nx = EMPTY;
        endcase
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= EMPTY;
            Result     <= '0;
            ResultZero <= 1'b0;
            ResultOp   <= '0;
            skid_out   <= '0;
            skid_zero  <= 1'b0;
            skid_op    <= '0;
        end else begin
            state <= state_nx;
            if (load_head) begin
                Result     <= AluOut;
                ResultZero <= AluZero;
                ResultOp   <= AluOp;
            end else if (move_skid) begin
                Result     <= skid_out;
                ResultZero <= skid_zero;
                ResultOp   <= skid_op;
            end
            if (load_skid) begin
                skid_out  <= AluOut;
                skid_zero <= AluZero;
                skid_op   <= AluOp;
            end
        end
    end
`ifdef ALU_RESULT_STATS_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            AcceptCount <= '0;
            ZeroCount   <= '0;
        end else if (push) begin
            AcceptCount <= AcceptCount + 16'(AcceptCount != 16'hFFFF);
            ZeroCount   <= ZeroCount + 16'(AluZero && ZeroCount != 16'hFFFF);
        end
    end
`endif
endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: queue-model checker plus directed vectors for alu_result_buffer
module tb_alu_result_buffer;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] AluOut = '0;
    logic        AluZero = 1'b0;
    logic [3:0]  AluOp = '0;
    logic        InValid = 1'b0;
    logic        OutReady = 1'b0;
    logic        InReady, ResultZero, OutValid;
    logic [31:0] Result;
    logic [3:0]  ResultOp;
`ifdef ALU_RESULT_STATS_EN
    logic [15:0] AcceptCount, ZeroCount;
`endif
    int tests = 0;
    int fails = 0;
    alu_result_buffer dut (
        .Clk(Clk), .Reset(Reset), .AluOut(AluOut), .AluZero(AluZero), .AluOp(AluOp),
        .InValid(InValid), .InReady(InReady), .Result(Result), .ResultZero(ResultZero),
        .ResultOp(ResultOp), .OutValid(OutValid), .OutReady(OutReady)
`ifdef ALU_RESULT_STATS_EN
        , .AcceptCount(AcceptCount), .ZeroCount(ZeroCount)
`endif
    );
    always #5 Clk = ~Clk;
    typedef struct {
        logic [31:0] d;
        logic        z;
        logic [3:0]  op;
    } ent_t;
    ent_t q[$];
    ent_t head_m, tmp;
    int   acc_m, zc_m;
    bit   started = 0;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
        end
    endtask
    always @(posedge Clk) begin
        if (Reset) begin
            q.delete();
            head_m = '{32'd0, 1'b0, 4'd0};
            acc_m = 0;
            zc_m = 0;
            started = 1;
        end else begin
            automatic bit ps = InValid && q.size() < 2;
            automatic bit pp = q.size() > 0 && OutReady;
            if (pp) tmp = q.pop_front();
            if (ps) begin
                q.push_back('{AluOut, AluZero, AluOp});
                if (acc_m < 65535) acc_m++;
                if (AluZero && zc_m < 65535) zc_m++;
            end
            if (q.size() > 0) head_m = q[0];
        end
    end
    always @(negedge Clk) begin
        if (started) begin
            chk("m_outvalid", {31'd0, OutValid}, {31'd0, q.size() != 0});
            chk("m_inready", {31'd0, InReady}, {31'd0, q.size() < 2});
            chk("m_result", Result, head_m.d);
            chk("m_zero", {31'd0, ResultZero}, {31'd0, head_m.z});
            chk("m_op", {28'd0, ResultOp}, {28'd0, head_m.op});
`ifdef ALU_RESULT_STATS_EN
            chk("m_acc", {16'd0, AcceptCount}, acc_m);
            chk("m_zc", {16'd0, ZeroCount}, zc_m);
`endif
        end
    end
    task automatic drive(input bit v, input logic [31:0] d, input bit z, input logic [3:0] op, input bit r);
        InValid = v;
        AluOut = d;
        AluZero = z;
        AluOp = op;
        OutReady = r;
        @(posedge Clk);
        #2;
    endtask
    initial begin
        repeat (2) @(posedge Clk);
        #2;
        chk("rst_outvalid", {31'd0, OutValid}, 0);
        chk("rst_inready", {31'd0, InReady}, 1);
        chk("rst_result", Result, 0);
        chk("rst_zero", {31'd0, ResultZero}, 0);
        chk("rst_op", {28'd0, ResultOp}, 0);
        Reset = 1'b0;
        drive(1, 3, 0, 0, 1);
        chk("single_valid", {31'd0, OutValid}, 1);
        chk("single_result", Result, 3);
        drive(0, 0, 0, 0, 1);
        chk("single_drain", {31'd0, OutValid}, 0);
        chk("single_hold", Result, 3);
        drive(1, 3, 0, 0, 0);
        chk("bp_first_inready", {31'd0, InReady}, 1);
        drive(1, 1, 1, 2, 0);
        chk("bp_full_inready", {31'd0, InReady}, 0);
        chk("bp_head_stable", Result, 3);
        drive(1, 5, 0, 0, 0);
        chk("bp_rejected_head", Result, 3);
        chk("bp_still_full", {31'd0, InReady}, 0);
        drive(0, 0, 0, 0, 1);
        chk("bp_pop1_result", Result, 1);
        chk("bp_pop1_zero", {31'd0, ResultZero}, 1);
        chk("bp_pop1_op", {28'd0, ResultOp}, 2);
        chk("bp_pop1_inready", {31'd0, InReady}, 1);
        drive(0, 0, 0, 0, 1);
        chk("bp_empty", {31'd0, OutValid}, 0);
        drive(1, 7, 0, 7, 0);
        chk("pp_head7", Result, 7);
        drive(1, 9, 1, 9, 1);
        chk("pp_head9", Result, 9);
        chk("pp_valid", {31'd0, OutValid}, 1);
        chk("pp_inready", {31'd0, InReady}, 1);
        drive(0, 0, 0, 0, 1);
        drive(1, 2, 0, 1, 0);
        drive(1, 4, 0, 1, 0);
        chk("two_inready", {31'd0, InReady}, 0);
        Reset = 1'b1;
        drive(0, 0, 0, 0, 1);
        chk("midrst_outvalid", {31'd0, OutValid}, 0);
        chk("midrst_inready", {31'd0, InReady}, 1);
        chk("midrst_result", Result, 0);
        Reset = 1'b0;
        drive(0, 0, 0, 0, 1);
        chk("midrst_noout", {31'd0, OutValid}, 0);
        for (int i = 0; i < 48; i++)
            drive(i % 3 != 2, 32'(i * 37 + 1), i % 5 == 0, 4'(i), i % 4 != 0);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
`ifdef ALU_RESULT_STATS_EN
        Reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        Reset = 1'b0;
        chk("st_rst_acc", {16'd0, AcceptCount}, 0);
        drive(1, 0, 1, 0, 1);
        drive(1, 6, 0, 1, 1);
        drive(1, 0, 1, 2, 1);
        drive(1, 8, 0, 3, 1);
        chk("st_acc4", {16'd0, AcceptCount}, 4);
        chk("st_zc2", {16'd0, ZeroCount}, 2);
        for (int i = 0; i < 65536; i++) drive(1, 32'(i + 1), 0, 0, 1);
        chk("st_acc_sat", {16'd0, AcceptCount}, 32'h0000FFFF);
        chk("st_zc_held", {16'd0, ZeroCount}, 2);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
